// File: rtl/ivp_pkg.sv
// ivp_pkg: shared constants and helpers for the ivp_pipe inverter pipeline.
//   - IVP_PIPE_{BEST,TYP,WORST}_{RISE,FALL}: clock-to-output delays. They are
//     used only when IVP_PIPE_TIMING_EN is defined.
//   - IVP_PIPE_SETUP / IVP_PIPE_HOLD: input timing-check limits.
//   - occ_w(depth): width of the occupancy counter. It must hold 0..depth.
package ivp_pkg;

  localparam int IVP_PIPE_BEST_RISE  = 1;
  localparam int IVP_PIPE_TYP_RISE   = 2;
  localparam int IVP_PIPE_WORST_RISE = 3;
  localparam int IVP_PIPE_BEST_FALL  = 1;
  localparam int IVP_PIPE_TYP_FALL   = 2;
  localparam int IVP_PIPE_WORST_FALL = 3;
  localparam int IVP_PIPE_SETUP      = 1;
  localparam int IVP_PIPE_HOLD       = 1;

  // Counter width large enough to represent every value 0..depth.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ivp_stage.sv
// ivp_stage: one register slot of the ivp_pipe pipeline. It holds a W-bit data
// register and a valid bit.
// Ports:
//   CP      rising-edge clock
//   R       synchronous active-high reset (clears data and valid)
//   d_i     incoming data
//   v_i     incoming valid
//   rdy_in  ready from the next stage (or downstream)
//   rdy_out ready toward the previous stage: empty, or the next stage advances
//   d_o     held data
//   v_o     held valid
module ivp_stage import ivp_pkg::*; #(
  parameter int W = 8
) (
  input  logic         CP,
  input  logic         R,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  input  logic         rdy_in,
  output logic         rdy_out,
  output logic [W-1:0] d_o,
  output logic         v_o
);

  logic [W-1:0] data_q, data_d;
  logic         vld_q, vld_d;

  // An empty slot is always ready. This lets bubbles collapse behind a
  // stalled output.
  assign rdy_out = !vld_q | rdy_in;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (rdy_out) begin
      vld_d = v_i;
      // Data loads only with a real beat. A bubble leaves the old value in place.
      if (v_i) begin
        data_d = d_i;
      end else begin
        data_d = data_q;
      end
    end else begin
      vld_d  = vld_q;
      data_d = data_q;
    end
  end

  always_ff @(posedge CP) begin
    if (R) begin
      data_q <= {W{1'b0}};
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign d_o = data_q;
  assign v_o = vld_q;

endmodule

// File: rtl/ivp_pipe.sv
// ivp_pipe: a W-bit, DEPTH-stage registered inverter bank. Each beat carries
// its own mode: 1 inverts A, 0 passes A. The pipeline uses valid/ready flow
// control with bubble collapsing, and OCC reports how many stages are valid.
// Optional macro: IVP_PIPE_TIMING_EN adds a specify block with CP->Z/ZV paths
// and setup/hold checks. Without it the model is zero-delay.
// Ports:
//   CP   rising-edge clock            R    synchronous active-high reset
//   A    input beat data              AV   A valid
//   AR   ready to upstream            INV  mode sampled with the beat
//   Z    registered output data       ZV   registered output valid
//   ZR   downstream ready             OCC  registered count of valid stages
module ivp_pipe import ivp_pkg::*; #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int OW    = occ_w(DEPTH)
) (
  input  logic          CP,
  input  logic          R,
  input  logic [W-1:0]  A,
  input  logic          AV,
  output logic          AR,
  input  logic          INV,
  output logic [W-1:0]  Z,
  output logic          ZV,
  input  logic          ZR,
  output logic [OW-1:0] OCC
);

  // Index 0 is the stage-0 input. Index k+1 is the output of stage k.
  logic [DEPTH:0][W-1:0] sdat;
  logic [DEPTH:0]        svld;
  logic [DEPTH:0]        rdy;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  acc, emit;

  assign sdat[0]    = A ^ {W{INV}};
  assign svld[0]    = AV;
  assign rdy[DEPTH] = ZR;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    ivp_stage #(.W(W)) u_stage (
      .CP      (CP),
      .R       (R),
      .d_i     (sdat[k]),
      .v_i     (svld[k]),
      .rdy_in  (rdy[k+1]),
      .rdy_out (rdy[k]),
      .d_o     (sdat[k+1]),
      .v_o     (svld[k+1])
    );
  end

  assign AR   = rdy[0] & !R;
  assign Z    = sdat[DEPTH];
  assign ZV   = svld[DEPTH];
  assign acc  = AV & AR;
  assign emit = ZV & ZR;

  // An accept and an emit on the same edge cancel, so OCC stays within 0..DEPTH.
  always_comb begin
    occ_d = occ_q;
    if (acc != emit) begin
      occ_d = occ_q + OW'(acc) - OW'(emit);
    end else begin
      occ_d = occ_q;
    end
  end

  always_ff @(posedge CP) begin
    if (R) begin
      occ_q <= {OW{1'b0}};
    end else begin
      occ_q <= occ_d;
    end
  end

  assign OCC = occ_q;

`ifdef IVP_PIPE_TIMING_EN
  specify
    (posedge CP *> (Z : A)) = (IVP_PIPE_BEST_RISE:IVP_PIPE_TYP_RISE:IVP_PIPE_WORST_RISE,
                               IVP_PIPE_BEST_FALL:IVP_PIPE_TYP_FALL:IVP_PIPE_WORST_FALL);
    (posedge CP => (ZV : AV)) = (IVP_PIPE_BEST_RISE:IVP_PIPE_TYP_RISE:IVP_PIPE_WORST_RISE,
                                 IVP_PIPE_BEST_FALL:IVP_PIPE_TYP_FALL:IVP_PIPE_WORST_FALL);
    $setup(A,   posedge CP, IVP_PIPE_SETUP);
    $setup(AV,  posedge CP, IVP_PIPE_SETUP);
    $setup(INV, posedge CP, IVP_PIPE_SETUP);
    $setup(ZR,  posedge CP, IVP_PIPE_SETUP);
    $hold(posedge CP, A,   IVP_PIPE_HOLD);
    $hold(posedge CP, AV,  IVP_PIPE_HOLD);
    $hold(posedge CP, INV, IVP_PIPE_HOLD);
    $hold(posedge CP, ZR,  IVP_PIPE_HOLD);
  endspecify
`else
`endif

endmodule

// File: tb/tb_ivp_pipe.sv
// tb_ivp_pipe: drives a DEPTH=2 and a DEPTH=4 ivp_pipe with identical inputs.
// It compares both against a beat-position model that holds, for each DUT, an
// ordered list of in-flight beats and their positions.
module tb_ivp_pipe;

  logic       clk;
  logic       r, av, inv, zr;
  logic [7:0] a;
  logic       ar2, zv2, ar4, zv4;
  logic [7:0] z2, z4;
  logic [1:0] occ2;
  logic [2:0] occ4;

  int checks;
  int errors;
  bit primed;

  // Model state for each DUT: oldest beat first, with its position 0..D-1.
  int         dep [2];
  int         cnt [2];
  int         mp  [2][8];
  logic [7:0] md  [2][8];
  logic [7:0] zl  [2];

  ivp_pipe #(.W(8), .DEPTH(2)) u2 (
    .CP(clk), .R(r), .A(a), .AV(av), .AR(ar2), .INV(inv),
    .Z(z2), .ZV(zv2), .ZR(zr), .OCC(occ2)
  );

  ivp_pipe #(.W(8), .DEPTH(4)) u4 (
    .CP(clk), .R(r), .A(a), .AV(av), .AR(ar4), .INV(inv),
    .Z(z4), .ZV(zv4), .ZR(zr), .OCC(occ4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance model u across one clock edge using the current inputs.
  // Returns the AR value expected before that edge.
  task automatic model_edge(input int u, output bit ar_e);
    int d, lim, np;
    int newp [8];
    int nc;
    if (r) begin
      ar_e   = 1'b0;
      cnt[u] = 0;
      zl[u]  = 8'h00;
      return;
    end
    d   = dep[u];
    // The position just past the last stage is free only if downstream is ready.
    lim = zr ? d + 1 : d;
    for (int i = 0; i < cnt[u]; i++) begin
      np = mp[u][i] + 1;
      if (np > lim - 1) np = lim - 1;
      if (np < mp[u][i]) np = mp[u][i];
      if (np == d - 1 && mp[u][i] != d - 1) zl[u] = md[u][i];
      newp[i] = np;
      lim     = np;
    end
    ar_e = (lim >= 1);
    nc = 0;
    for (int i = 0; i < cnt[u]; i++) begin
      if (newp[i] < d) begin
        mp[u][nc] = newp[i];
        md[u][nc] = md[u][i];
        nc++;
      end
    end
    if (ar_e && av) begin
      mp[u][nc] = 0;
      md[u][nc] = inv ? ~a : a;
      if (d == 1) zl[u] = inv ? ~a : a;
      nc++;
    end
    cnt[u] = nc;
  endtask

  task automatic cycle(input bit r_i, input bit av_i, input logic [7:0] a_i,
                       input bit inv_i, input bit zr_i);
    bit e;
    @(negedge clk);
    r = r_i; av = av_i; a = a_i; inv = inv_i; zr = zr_i;
    #1;
    if (primed) begin
      chk("zv2",  {31'd0, zv2}, {31'd0, (cnt[0] > 0 && mp[0][0] == dep[0] - 1)});
      chk("occ2", {30'd0, occ2}, cnt[0]);
      chk("z2",   {24'd0, z2},   {24'd0, zl[0]});
      chk("zv4",  {31'd0, zv4}, {31'd0, (cnt[1] > 0 && mp[1][0] == dep[1] - 1)});
      chk("occ4", {29'd0, occ4}, cnt[1]);
      chk("z4",   {24'd0, z4},   {24'd0, zl[1]});
    end
    model_edge(0, e);
    chk("ar2", {31'd0, ar2}, {31'd0, e});
    model_edge(1, e);
    chk("ar4", {31'd0, ar4}, {31'd0, e});
    if (r_i) primed = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; primed = 1'b0;
    dep[0] = 2; dep[1] = 4;
    cnt[0] = 0; cnt[1] = 0;
    zl[0] = 8'h00; zl[1] = 8'h00;
    r = 1'b1; av = 1'b0; a = 8'h00; inv = 1'b0; zr = 1'b1;

    // Reset for two cycles with AV held high.
    cycle(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);

    // Streaming: 3C inverted, then 3C passed.
    cycle(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Backpressure: offer three beats into a stalled output, then drain.
    cycle(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h22, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill both pipes, then run accept and emit together for ten cycles.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'(8'h80 + i), i[0], 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Bubble collapse: gapped beats into a stalled output.
    for (int i = 0; i < 9; i++) cycle(1'b0, (i % 3) != 1, 8'(8'hC0 + i), 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Mid-operation reset with two beats in flight.
    cycle(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'hE2, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
